ex_hazard_controller: RTL and testbench

Pipeline hazard controller that sequences the execute stage and its neighbouring pipeline registers. It keeps a shadow scoreboard of the destination, read sources and control bits of the instructions in EX, MEM and WB. From that scoreboard it drives the ALU operand forwarding selects, load-use stall and bubble insertion, and flushes after a taken branch. It sits beside the ID/EX, EX/MEM and MEM/WB registers; its outputs gate PC, IF/ID and ID/EX updates and steer the ALU input multiplexers.

---
 rtl/ex_hazard_controller.sv | 185 ++++++++++++++++++
 tb/tb_ex_hazard_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_controller.sv
// ex_hazard_controller: hazard sequencing for the execute stage.
// Keeps a shadow scoreboard of EX/MEM/WB and drives ALU forwarding selects,
// load-use stall/bubble and taken-branch flushes.
// Build option: define HAZARD_FWD_EN for operand forwarding with a 1-cycle
// load-use stall; when undefined, forwarding is off and any RAW match stalls
// in RAW_WAIT until the producer has left the hazard window.
module ex_hazard_controller #(
  parameter bit RF_WRITE_THROUGH = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_RegWrite,
  input  logic       id_MemRead,
  input  logic       id_branch,
  input  logic [4:0] id_dest,
  input  logic       mem_branch_taken,
  output logic       stall,
  output logic       bubble_idex,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic       flush_exmem,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       busy
);

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic [4:0] dest;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
  } slot_t;

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] LOAD_STALL = 2'd1;
  localparam logic [1:0] BR_FLUSH   = 2'd2;
`ifndef HAZARD_FWD_EN
  localparam logic [1:0] RAW_WAIT   = 2'd3;
`endif

  slot_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0] state_q, state_d;
`ifndef HAZARD_FWD_EN
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] raw_len;
`endif

  logic ex_prod, mem_prod, wb_prod;
  logic hit_ex, hit_mem, hit_wb;
  logic unused_ok;

  // Producer qualification and ID-source matches against each slot
  always_comb begin
    ex_prod  = ex_q.valid  & ex_q.reg_write  & (ex_q.dest  != 5'd0);
    mem_prod = mem_q.valid & mem_q.reg_write & (mem_q.dest != 5'd0);
    wb_prod  = wb_q.valid  & wb_q.reg_write  & (wb_q.dest  != 5'd0);
    hit_ex   = id_valid & ex_prod &
               ((id_uses_rs & (id_rs == ex_q.dest)) | (id_uses_rt & (id_rt == ex_q.dest)));
    hit_mem  = id_valid & mem_prod &
               ((id_uses_rs & (id_rs == mem_q.dest)) | (id_uses_rt & (id_rt == mem_q.dest)));
    hit_wb   = id_valid & wb_prod &
               ((id_uses_rs & (id_rs == wb_q.dest)) | (id_uses_rt & (id_rt == wb_q.dest)));
  end

  // Outputs and next state; a taken branch overrides any stall
  always_comb begin
    stall       = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    busy        = 1'b0;
    state_d     = state_q;
`ifndef HAZARD_FWD_EN
    cnt_d       = cnt_q;
    // Stall cycles left until the youngest matching producer exits the window
    if (hit_ex)       raw_len = RF_WRITE_THROUGH ? 2'd2 : 2'd3;
    else if (hit_mem) raw_len = RF_WRITE_THROUGH ? 2'd1 : 2'd2;
    else              raw_len = 2'd1;
`endif
    if (!rst) begin
      busy = (state_q != RUN);
`ifdef HAZARD_FWD_EN
      if (ex_q.valid) begin
        if (mem_prod && (mem_q.dest == ex_q.rs))     fwd_a = 2'b10;
        else if (wb_prod && (wb_q.dest == ex_q.rs))  fwd_a = 2'b01;
        if (mem_prod && (mem_q.dest == ex_q.rt))     fwd_b = 2'b10;
        else if (wb_prod && (wb_q.dest == ex_q.rt))  fwd_b = 2'b01;
      end
`endif
      case (state_q)
        RUN: begin
`ifdef HAZARD_FWD_EN
          if (hit_ex && ex_q.mem_read) begin
            stall       = 1'b1;
            bubble_idex = 1'b1;
            state_d     = LOAD_STALL;
          end
`else
          if (hit_ex || hit_mem || (!RF_WRITE_THROUGH && hit_wb)) begin
            stall       = 1'b1;
            bubble_idex = 1'b1;
            if (raw_len > 2'd1) begin
              state_d = RAW_WAIT;
              cnt_d   = raw_len - 2'd1;
            end
          end
`endif
        end
        LOAD_STALL: state_d = RUN;
        BR_FLUSH:   state_d = RUN;
`ifndef HAZARD_FWD_EN
        RAW_WAIT: begin
          stall       = 1'b1;
          bubble_idex = 1'b1;
          cnt_d       = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RUN;
        end
`endif
        default: state_d = RUN;
      endcase
      if (mem_branch_taken) begin
        stall       = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
        flush_exmem = 1'b1;
        state_d     = BR_FLUSH;
      end
    end
  end

  // Scoreboard advance: bubble or flush empties EX, flush also empties MEM
  always_comb begin
    wb_d  = mem_q;
    mem_d = flush_exmem ? '0 : ex_q;
    ex_d  = '0;
    if (!(bubble_idex || flush_idex)) begin
      ex_d.valid     = id_valid;
      ex_d.reg_write = id_RegWrite;
      ex_d.mem_read  = id_MemRead;
      ex_d.dest      = id_dest;
      ex_d.rs        = id_rs;
      ex_d.rt        = id_rt;
      ex_d.uses_rs   = id_uses_rs;
      ex_d.uses_rt   = id_uses_rt;
    end
  end

  // State and scoreboard registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= RUN;
`ifndef HAZARD_FWD_EN
      cnt_q   <= '0;
`endif
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
`ifndef HAZARD_FWD_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Scoreboard fields and inputs not consumed in every build variant
  assign unused_ok = ^{ex_q, mem_q, wb_q, id_branch, hit_mem, hit_wb, RF_WRITE_THROUGH};

endmodule

// File: tb/tb_ex_hazard_controller.sv
module tb_ex_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt, id_RegWrite, id_MemRead, id_branch;
  logic       mem_branch_taken;
  logic       stall, bubble_idex, flush_ifid, flush_idex, flush_exmem, busy;
  logic [1:0] fwd_a, fwd_b;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef logic [19:0] ins_t;
  typedef struct {
    string      tag;
    logic       rst;
    ins_t       ins;
    logic       mbt;
    logic [9:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [9:0] sb_q[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  ex_hazard_controller #(.RF_WRITE_THROUGH(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_RegWrite(id_RegWrite),
    .id_MemRead(id_MemRead), .id_branch(id_branch), .id_dest(id_dest),
    .mem_branch_taken(mem_branch_taken), .stall(stall), .bubble_idex(bubble_idex),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .busy(busy)
  );

  function automatic ins_t mk(input logic vld, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic rw,
                              input logic mr, input logic [4:0] dst);
    return {vld, rs, rt, urs, urt, rw, mr, dst};
  endfunction

  function automatic logic [9:0] e(input logic st, input logic bb, input logic fl,
                                   input logic [1:0] fa, input logic [1:0] fb, input logic bz);
    return {st, bb, fl, fl, fl, fa, fb, bz};
  endfunction

  task automatic vec(input string tag, input logic r, input ins_t i, input logic mbt,
                     input logic [9:0] exp_fwd, input logic [9:0] exp_nofwd);
    vec_t v;
    v.tag = tag; v.rst = r; v.ins = i; v.mbt = mbt;
    v.exp = FWD ? exp_fwd : exp_nofwd;
    tbl.push_back(v);
  endtask

  initial begin
    ins_t NOP, LW2, ADD3, ADD2, SUB5, ADDI2, OR6, LW0, ADD7, RD2_INV;
    logic [9:0] Z, SB, SBB, BSY, FL, F0100, F1000, F1010, F0101;
    logic [9:0] got, expv;

    rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dest = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_RegWrite = 1'b0; id_MemRead = 1'b0;
    id_branch = 1'b0; mem_branch_taken = 1'b0;

    NOP     = '0;
    LW2     = mk(1, 5'd1, 5'd0, 1, 0, 1, 1, 5'd2);
    ADD3    = mk(1, 5'd2, 5'd4, 1, 1, 1, 0, 5'd3);
    ADD2    = mk(1, 5'd1, 5'd1, 1, 1, 1, 0, 5'd2);
    SUB5    = mk(1, 5'd2, 5'd2, 1, 1, 1, 0, 5'd5);
    ADDI2   = mk(1, 5'd1, 5'd0, 1, 0, 1, 0, 5'd2);
    OR6     = mk(1, 5'd2, 5'd0, 1, 1, 1, 0, 5'd6);
    LW0     = mk(1, 5'd1, 5'd0, 1, 0, 1, 1, 5'd0);
    ADD7    = mk(1, 5'd0, 5'd0, 1, 1, 1, 0, 5'd7);
    RD2_INV = mk(0, 5'd2, 5'd2, 1, 1, 1, 0, 5'd8);

    Z     = e(0, 0, 0, 2'b00, 2'b00, 0);
    SB    = e(1, 1, 0, 2'b00, 2'b00, 0);
    SBB   = e(1, 1, 0, 2'b00, 2'b00, 1);
    BSY   = e(0, 0, 0, 2'b00, 2'b00, 1);
    FL    = e(0, 0, 1, 2'b00, 2'b00, 0);
    F0100 = e(0, 0, 0, 2'b01, 2'b00, 0);
    F1000 = e(0, 0, 0, 2'b10, 2'b00, 0);
    F1010 = e(0, 0, 0, 2'b10, 2'b10, 0);
    F0101 = e(0, 0, 0, 2'b01, 2'b01, 0);

    vec("lu_rst",   1, NOP,  0, Z,     Z);
    vec("lu_lw",    0, LW2,  0, Z,     Z);
    vec("lu_stall", 0, ADD3, 0, SB,    SB);
    vec("lu_busy",  0, ADD3, 0, BSY,   SBB);
    vec("lu_fwd",   0, ADD3, 0, F0100, Z);
    vec("lu_tail1", 0, NOP,  0, Z,     Z);
    vec("lu_tail2", 0, NOP,  0, Z,     Z);
    vec("rs_rst",   1, NOP,  0, Z,     Z);
    vec("rs_lw",    0, LW2,  0, Z,     Z);
    vec("rs_stall", 0, ADD3, 0, SB,    SB);
    vec("rs_mid",   1, ADD3, 0, Z,     Z);
    vec("rs_after", 0, ADD3, 0, Z,     Z);
    vec("rs_clean", 0, NOP,  0, Z,     Z);
    vec("aa_rst",   1, NOP,  0, Z,     Z);
    vec("aa_add",   0, ADD2, 0, Z,     Z);
    vec("aa_sub",   0, SUB5, 0, Z,     SB);
    vec("aa_fwd10", 0, SUB5, 0, F1010, SBB);
    vec("aa_fwd01", 0, SUB5, 0, F0101, Z);
    vec("aa_tail1", 0, NOP,  0, Z,     Z);
    vec("aa_tail2", 0, NOP,  0, Z,     Z);
    vec("pr_rst",   1, NOP,   0, Z,     Z);
    vec("pr_add",   0, ADD2,  0, Z,     Z);
    vec("pr_addi",  0, ADDI2, 0, Z,     Z);
    vec("pr_or",    0, OR6,   0, Z,     SB);
    vec("pr_mem",   0, OR6,   0, F1000, SBB);
    vec("pr_wb",    0, OR6,   0, F0100, Z);
    vec("pr_tail1", 0, NOP,   0, Z,     Z);
    vec("pr_tail2", 0, NOP,   0, Z,     Z);
    vec("r0_rst",   1, NOP,  0, Z,     Z);
    vec("r0_lw0",   0, LW0,  0, Z,     Z);
    vec("r0_rd",    0, ADD7, 0, Z,     Z);
    vec("r0_ex",    0, NOP,  0, Z,     Z);
    vec("r0_tail",  0, NOP,  0, Z,     Z);
    vec("br_rst",   1, NOP,  0, Z,     Z);
    vec("br_lw",    0, LW2,  0, Z,     Z);
    vec("br_flush", 0, ADD3, 1, FL,    FL);
    vec("br_busy",  0, ADD3, 0, BSY,   BSY);
    vec("br_ex",    0, NOP,  0, Z,     Z);
    vec("br_tail",  0, NOP,  0, Z,     Z);
    vec("iv_rst",   1, NOP,     0, Z, Z);
    vec("iv_lw",    0, LW2,     0, Z, Z);
    vec("iv_rd",    0, RD2_INV, 0, Z, Z);
    vec("iv_tail",  0, NOP,     0, Z, Z);
    vec("gp_rst",   1, NOP,  0, Z,     Z);
    vec("gp_add",   0, ADD2, 0, Z,     Z);
    vec("gp_nop",   0, NOP,  0, Z,     Z);
    vec("gp_sub",   0, SUB5, 0, Z,     SB);
    vec("gp_wb",    0, SUB5, 0, F0101, Z);
    vec("gp_tail",  0, NOP,  0, Z,     Z);

    @(posedge clk);
    @(negedge clk);
    #2;
    got = {stall, bubble_idex, flush_ifid, flush_idex, flush_exmem, fwd_a, fwd_b, busy};
    checks++;
    if (got !== Z) begin
      errors++;
      $display("FAIL reset_state got %b expected %b", got, Z);
    end

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      {id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_RegWrite, id_MemRead, id_dest} = tbl[i].ins;
      mem_branch_taken = tbl[i].mbt;
      sb_q.push_back(tbl[i].exp);
      #2;
      got  = {stall, bubble_idex, flush_ifid, flush_idex, flush_exmem, fwd_a, fwd_b, busy};
      expv = sb_q.pop_front();
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL %s [%0d] {stall,bub,flush3,fa,fb,busy} got %b expected %b",
                 tbl[i].tag, i, got, expv);
      end
    end

    @(negedge clk);
    rst = 1'b0;
    {id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_RegWrite, id_MemRead, id_dest} = NOP;
    mem_branch_taken = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    got = {stall, bubble_idex, flush_ifid, flush_idex, flush_exmem, fwd_a, fwd_b, busy};
    checks++;
    if (got !== Z) begin
      errors++;
      $display("FAIL expired_wait got %b expected %b", got, Z);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
